// File: rtl/psum_merge_acc.sv
// Merges per-lane partial sums per column and accumulates them over acc_passes+1 captures.
// Define PSUM_MERGE_SAT_EN to saturate accumulator updates instead of wrapping.
module psum_merge_acc #(
  parameter int NUM_SUB_MACROS    = 4,
  parameter int NUM_COLS          = 32,
  parameter int ODATA_WIDTH       = 20,
  parameter int ODATA_WIDTH_FINAL = 22,
  parameter int PASS_CNT_WIDTH    = 4
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [NUM_SUB_MACROS*NUM_COLS*ODATA_WIDTH-1:0] psum_buff_out,
  input  logic [NUM_SUB_MACROS-1:0]                     psum_data_ready,
  output logic [NUM_SUB_MACROS-1:0]                     psum_ack,
  input  logic [NUM_SUB_MACROS-1:0]                     merge_mask,
  input  logic [PASS_CNT_WIDTH-1:0]                     acc_passes,
  output logic [NUM_COLS*ODATA_WIDTH_FINAL-1:0]         psum_final,
  output logic                                          psum_final_valid,
  input  logic                                          psum_final_ready
);

  localparam int NS = NUM_SUB_MACROS;
  localparam int NC = NUM_COLS;
  localparam int W  = ODATA_WIDTH;
  localparam int FW = ODATA_WIDTH_FINAL;
  localparam int DW = NS * NC * W;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    SUM    = 2'd1,
    OUT    = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [PASS_CNT_WIDTH-1:0] pass_q, pass_d;
  logic [PASS_CNT_WIDTH-1:0] passes_q, passes_d;
  logic [NS-1:0]             mask_q, mask_d;
  logic [NS-1:0]             ack_q, ack_d;
  logic                      valid_q, valid_d;
  logic [DW-1:0]             data_q;
  logic [NC*FW-1:0]          acc_q;
  logic [NC*FW-1:0]          final_q;
  logic [DW-1:0]             masked_s;
  logic [NC*FW-1:0]          acc_next_s;
  logic [NS-1:0]             eff_mask_s;
  logic [PASS_CNT_WIDTH-1:0] eff_passes_s;
  logic                      capture_s;
  logic                      acc_en_s;
  logic                      final_en_s;

  function automatic logic [FW-1:0] sext_lane(input logic [W-1:0] v);
    return {{(FW-W){v[W-1]}}, v};
  endfunction

  // first pass loads the tree sum; later passes add it to the running accumulator
  function automatic logic [FW-1:0] acc_update(input logic [FW-1:0] acc, input logic [FW-1:0] tree,
                                               input logic first);
`ifdef PSUM_MERGE_SAT_EN
    logic [FW:0] wide;
    if (first) begin
      wide = {tree[FW-1], tree};
    end else begin
      wide = {acc[FW-1], acc} + {tree[FW-1], tree};
    end
    if (wide[FW] != wide[FW-1]) begin
      return wide[FW] ? {1'b1, {(FW-1){1'b0}}} : {1'b0, {(FW-1){1'b1}}};
    end else begin
      return wide[FW-1:0];
    end
`else
    return first ? tree : acc + tree;
`endif
  endfunction

  // Mask and pass count come from the inputs at pass 0, from the latched copies afterwards.
  always_comb begin
    eff_mask_s   = (pass_q == {PASS_CNT_WIDTH{1'b0}}) ? merge_mask : mask_q;
    eff_passes_s = (pass_q == {PASS_CNT_WIDTH{1'b0}}) ? acc_passes : passes_q;
    masked_s     = {DW{1'b0}};
    for (int s = 0; s < NS; s++) begin
      for (int c = 0; c < NC; c++) begin
        if (eff_mask_s[s]) begin
          masked_s[(s*NC+c)*W +: W] = psum_buff_out[(s*NC+c)*W +: W];
        end else begin
          masked_s[(s*NC+c)*W +: W] = {W{1'b0}};
        end
      end
    end
  end

  // Per-column adder tree over captured lanes plus accumulator update.
  always_comb begin
    logic [FW-1:0] col_sum;
    col_sum    = {FW{1'b0}};
    acc_next_s = {(NC*FW){1'b0}};
    for (int c = 0; c < NC; c++) begin
      col_sum = {FW{1'b0}};
      for (int s = 0; s < NS; s++) begin
        col_sum = col_sum + sext_lane(data_q[(s*NC+c)*W +: W]);
      end
      acc_next_s[c*FW +: FW] = acc_update(acc_q[c*FW +: FW], col_sum,
                                          pass_q == {PASS_CNT_WIDTH{1'b0}});
    end
  end

  // Control FSM next-state and strobes.
  always_comb begin
    state_d    = state_q;
    pass_d     = pass_q;
    passes_d   = passes_q;
    mask_d     = mask_q;
    ack_d      = {NS{1'b0}};
    valid_d    = valid_q;
    capture_s  = 1'b0;
    acc_en_s   = 1'b0;
    final_en_s = 1'b0;
    case (state_q)
      ACCEPT: begin
        if ((eff_mask_s != {NS{1'b0}}) && ((psum_data_ready & eff_mask_s) == eff_mask_s)) begin
          capture_s = 1'b1;
          ack_d     = eff_mask_s;
          mask_d    = eff_mask_s;
          passes_d  = eff_passes_s;
          state_d   = SUM;
        end else begin
          state_d = ACCEPT;
        end
      end
      SUM: begin
        acc_en_s = 1'b1;
        if (pass_q == passes_q) begin
          pass_d     = {PASS_CNT_WIDTH{1'b0}};
          final_en_s = 1'b1;
          valid_d    = 1'b1;
          state_d    = OUT;
        end else begin
          pass_d  = pass_q + {{(PASS_CNT_WIDTH-1){1'b0}}, 1'b1};
          state_d = ACCEPT;
        end
      end
      OUT: begin
        if (psum_final_ready) begin
          valid_d = 1'b0;
          state_d = ACCEPT;
        end else begin
          state_d = OUT;
        end
      end
      default: begin
        state_d = ACCEPT;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ACCEPT;
      pass_q   <= {PASS_CNT_WIDTH{1'b0}};
      passes_q <= {PASS_CNT_WIDTH{1'b0}};
      mask_q   <= {NS{1'b0}};
      ack_q    <= {NS{1'b0}};
      valid_q  <= 1'b0;
      data_q   <= {DW{1'b0}};
      acc_q    <= {(NC*FW){1'b0}};
      final_q  <= {(NC*FW){1'b0}};
    end else begin
      state_q  <= state_d;
      pass_q   <= pass_d;
      passes_q <= passes_d;
      mask_q   <= mask_d;
      ack_q    <= ack_d;
      valid_q  <= valid_d;
      if (capture_s) data_q <= masked_s;
      if (acc_en_s) acc_q <= acc_next_s;
      if (final_en_s) final_q <= acc_next_s;
    end
  end

  assign psum_ack         = ack_q;
  assign psum_final       = final_q;
  assign psum_final_valid = valid_q;

endmodule

// File: tb/tb_psum_merge_acc.sv
// Directed scoreboard bench for psum_merge_acc at default parameters.
module tb_psum_merge_acc;
  localparam int NS = 4;
  localparam int NC = 32;
  localparam int W  = 20;
  localparam int FW = 22;
  localparam int PW = 4;

  typedef struct {
    logic [FW-1:0] c0;
    logic [FW-1:0] c5;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NS*NC*W-1:0]  psum_buff_out;
  logic [NS-1:0]       psum_data_ready;
  logic [NS-1:0]       psum_ack;
  logic [NS-1:0]       merge_mask;
  logic [PW-1:0]       acc_passes;
  logic [NC*FW-1:0]    psum_final;
  logic                psum_final_valid;
  logic                psum_final_ready;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  exp_t e;

  psum_merge_acc dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .psum_buff_out   (psum_buff_out),
    .psum_data_ready (psum_data_ready),
    .psum_ack        (psum_ack),
    .merge_mask      (merge_mask),
    .acc_passes      (acc_passes),
    .psum_final      (psum_final),
    .psum_final_valid(psum_final_valid),
    .psum_final_ready(psum_final_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] col(input int c);
    return psum_final[c*FW +: FW];
  endfunction

  task automatic set_lane(input int s, input int c, input int v);
    psum_buff_out[(s*NC+c)*W +: W] = W'(v);
  endtask

  task automatic push(input int c0, input int c5);
    exp_t x;
    x.c0 = FW'(c0);
    x.c5 = FW'(c5);
    sb.push_back(x);
  endtask

  // Called at a negedge: present ready, capture on next posedge, check ack and valid timing.
  task automatic capture(input string tag, input logic [NS-1:0] rdy, input logic [NS-1:0] ack_exp,
                         input logic valid_exp);
    psum_data_ready = rdy;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_ack"}, 32'(psum_ack), 32'(ack_exp));
    check({tag, "_valid_n1"}, 32'(psum_final_valid), 32'd0);
    psum_data_ready = {NS{1'b0}};
    @(negedge clk);
    check({tag, "_valid_n2"}, 32'(psum_final_valid), 32'(valid_exp));
    check({tag, "_ack_n2"}, 32'(psum_ack), 32'd0);
  endtask

  task automatic compare_result(input string tag);
    exp_t x;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      x = sb.pop_front();
      check({tag, "_col0"}, 32'(col(0)), 32'(x.c0));
      check({tag, "_col5"}, 32'(col(5)), 32'(x.c5));
    end
  endtask

  task automatic release_result(input string tag);
    psum_final_ready = 1'b1;
    @(negedge clk);
    check({tag, "_valid_drop"}, 32'(psum_final_valid), 32'd0);
    psum_final_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    psum_buff_out = '0;
    psum_data_ready = 4'h0;
    merge_mask = 4'h0;
    acc_passes = 4'd0;
    psum_final_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(psum_ack), 32'd0);
    check("rst_valid", 32'(psum_final_valid), 32'd0);
    check("rst_col0", 32'(col(0)), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // single pass, full mask: col0 = 1+2+3+4, col5 = 4 * -5
    merge_mask = 4'hF;
    acc_passes = 4'd0;
    for (int s = 0; s < NS; s++) begin
      set_lane(s, 0, s + 1);
      set_lane(s, 5, -5);
    end
    push(10, -20);
    capture("single", 4'hF, 4'hF, 1'b1);
    compare_result("single");

    // result held while downstream stalls; no capture meanwhile
    psum_data_ready = 4'hF;
    repeat (5) begin
      @(negedge clk);
      check("hold_ack", 32'(psum_ack), 32'd0);
      check("hold_valid", 32'(psum_final_valid), 32'd1);
      check("hold_col0", 32'(col(0)), 32'd10);
    end
    release_result("hold");
    push(10, -20);
    capture("after_hold", 4'hF, 4'hF, 1'b1);
    compare_result("after_hold");
    release_result("after_hold");

    // empty mask never captures
    merge_mask = 4'h0;
    psum_data_ready = 4'hF;
    repeat (3) begin
      @(negedge clk);
      check("mask0_ack", 32'(psum_ack), 32'd0);
      check("mask0_valid", 32'(psum_final_valid), 32'd0);
    end

    // partial mask: only lanes 0 and 2 count
    merge_mask = 4'b0101;
    set_lane(0, 0, 7);
    set_lane(1, 0, 100);
    set_lane(2, 0, 9);
    set_lane(3, 0, 100);
    psum_data_ready = 4'b1010;
    repeat (3) begin
      @(negedge clk);
      check("wrong_ready_ack", 32'(psum_ack), 32'd0);
      check("wrong_ready_valid", 32'(psum_final_valid), 32'd0);
    end
    push(16, -10);
    capture("partial", 4'b0101, 4'b0101, 1'b1);
    compare_result("partial");
    release_result("partial");

    // three passes; inputs changed mid-group must be ignored
    merge_mask = 4'hF;
    acc_passes = 4'd2;
    for (int s = 0; s < NS; s++) set_lane(s, 0, s + 1);
    push(30, -60);
    capture("multi_p0", 4'hF, 4'hF, 1'b0);
    merge_mask = 4'b0001;
    acc_passes = 4'd0;
    capture("multi_p1", 4'hF, 4'hF, 1'b0);
    capture("multi_p2", 4'hF, 4'hF, 1'b1);
    compare_result("multi");
    release_result("multi");

    // overflow over three passes
    merge_mask = 4'hF;
    acc_passes = 4'd2;
    for (int s = 0; s < NS; s++) begin
      set_lane(s, 0, 524287);
      set_lane(s, 5, 0);
    end
`ifdef PSUM_MERGE_SAT_EN
    push(2097151, 0);
`else
    push(2097140, 0);
`endif
    capture("ovf_p0", 4'hF, 4'hF, 1'b0);
    capture("ovf_p1", 4'hF, 4'hF, 1'b0);
    capture("ovf_p2", 4'hF, 4'hF, 1'b1);
    compare_result("ovf");
    release_result("ovf");

    // reset mid-group, then a full fresh group is required
    capture("rst_p0", 4'hF, 4'hF, 1'b0);
    capture("rst_p1", 4'hF, 4'hF, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(psum_final_valid), 32'd0);
    check("midrst_ack", 32'(psum_ack), 32'd0);
    check("midrst_col0", 32'(col(0)), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`ifdef PSUM_MERGE_SAT_EN
    push(2097151, 0);
`else
    push(2097140, 0);
`endif
    capture("post_rst_p0", 4'hF, 4'hF, 1'b0);
    capture("post_rst_p1", 4'hF, 4'hF, 1'b0);
    capture("post_rst_p2", 4'hF, 4'hF, 1'b1);
    compare_result("post_rst");
    release_result("post_rst");
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
